// File: rtl/if_prefetch_queue.sv
// Fetch front end: issues in-order word fetches, buffers {pc, inst} in a DEPTH-entry FIFO, flushes on redirect.
// Build option PREFETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc4
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [31:0]      out_inst_q, out_inst_d;
  logic [31:0]      out_pc4_q, out_pc4_d;
  entry_t           mem_q [DEPTH];

  logic             fifo_vld;
  logic             accept;
  logic             push;
  logic             pop;
  logic             bypass;
  logic [CNT_W:0]   credits_used;
  logic [CNT_W-1:0] cnt_after_pop;
  entry_t           head_nxt;

  assign fifo_vld     = (count_q != '0);
  assign credits_used = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req     = rst_n && !redirect && (credits_used < (CNT_W+1)'(DEPTH));
  assign imem_addr    = fetch_pc_q;

`ifdef PREFETCH_BYPASS_EN
  assign bypass    = !fifo_vld && (discard_q == '0) && imem_rvalid && !hold && !redirect;
  assign out_valid = fifo_vld || bypass;
  assign out_inst  = bypass ? imem_rdata : out_inst_q;
  assign out_pc4   = bypass ? (resp_pc_q + 32'd4) : out_pc4_q;
`else
  assign bypass    = 1'b0;
  assign out_valid = fifo_vld;
  assign out_inst  = out_inst_q;
  assign out_pc4   = out_pc4_q;
`endif

  always_comb begin
    accept        = imem_req && imem_req_ready;
    pop           = fifo_vld && !hold && !redirect;
    push          = imem_rvalid && (discard_q == '0) && !redirect && !bypass;
    rd_ptr_d      = rd_ptr_q + AW'(pop);
    wr_ptr_d      = wr_ptr_q + AW'(push);
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    cnt_after_pop = count_q - CNT_W'(pop);
    outst_d       = outst_q + CNT_W'(accept) - CNT_W'(imem_rvalid);
    discard_d     = discard_q - CNT_W'(imem_rvalid && (discard_q != '0));
    fetch_pc_d    = accept ? (fetch_pc_q + 32'd4) : fetch_pc_q;
    resp_pc_d     = (push || bypass) ? (resp_pc_q + 32'd4) : resp_pc_q;
    head_nxt      = mem_q[rd_ptr_d];
    out_inst_d    = out_inst_q;
    out_pc4_d     = out_pc4_q;

    // Output registers track whatever will sit at the head after this edge.
    if (bypass || (push && (cnt_after_pop == '0))) begin
      out_inst_d = imem_rdata;
      out_pc4_d  = resp_pc_q + 32'd4;
    end else if (cnt_after_pop != '0) begin
      out_inst_d = head_nxt.inst;
      out_pc4_d  = head_nxt.pc + 32'd4;
    end

    // Every request still in flight belongs to the old path, including one answered now.
    if (redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      discard_d  = outst_q - CNT_W'(imem_rvalid);
      fetch_pc_d = redirect_addr;
      resp_pc_d  = redirect_addr;
      out_inst_d = out_inst_q;
      out_pc4_d  = out_pc4_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      out_inst_q <= '0;
      out_pc4_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      out_inst_q <= out_inst_d;
      out_pc4_q  <= out_pc4_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: resp_pc_q, inst: imem_rdata};
    end
  end

  a_rsp_needs_credit: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (outst_q != '0));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: in-order memory with tagged requests plus a queue-level reference of what decode must see.
module tb_if_prefetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_req_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc4;

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_addr(redirect_addr),
    .hold(hold), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_req_ready(imem_req_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc4(out_pc4)
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc4; } ent_t;

  mreq_t       env_q[$];
  ent_t        exp_q[$];
  logic [31:0] out_log[$];
  logic [31:0] inst_log[$];
  logic [31:0] issued_log[$];
  int          epoch, cyc, lat_min, lat_max, hold_pct, n_checks, n_fail;
  logic [31:0] exp_fetch, last_inst, last_pc4, stim_raddr;
  logic        stim_hold, stim_redirect, stim_ready, rand_ready;
  logic        obs_req, obs_valid, obs_rvalid;
  logic [31:0] obs_addr, obs_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, compare settled outputs, then advance the reference across the coming edge.
  task automatic cycle();
    mreq_t r;
    ent_t  e;
    logic  acc, fresh, exp_req;
    @(negedge clk);
    redirect       = stim_redirect;
    redirect_addr  = stim_raddr;
    hold           = (hold_pct > 0) ? ($urandom_range(0, 99) < hold_pct) : stim_hold;
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : stim_ready;
    if (env_q.size() != 0 && env_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(env_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = out_valid;
    obs_pc4 = out_pc4;  obs_rvalid = imem_rvalid;

    exp_req = !redirect && ((exp_q.size() + env_q.size()) < DEPTH);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, exp_fetch);
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      last_inst = exp_q[0].inst;
      last_pc4  = exp_q[0].pc4;
    end
    check("out_inst", out_inst, last_inst);
    check("out_pc4", out_pc4, last_pc4);

    acc = imem_req && imem_req_ready;
    if (acc) issued_log.push_back(imem_addr);
    if (redirect) exp_fetch = redirect_addr;
    else if (acc) exp_fetch = exp_fetch + 32'd4;
    fresh = 1'b0;
    if (imem_rvalid) begin
      r = env_q.pop_front();
      fresh = (r.epoch == epoch);
    end
    if (redirect) begin
      exp_q.delete();
      epoch++;
    end else begin
      if (exp_q.size() != 0 && !hold) begin
        e = exp_q.pop_front();
        out_log.push_back(e.pc4);
        inst_log.push_back(e.inst);
      end
      if (fresh) begin
        e.inst = mem_word(r.addr);
        e.pc4  = r.addr + 32'd4;
        exp_q.push_back(e);
      end
    end
    if (acc) env_q.push_back('{addr: imem_addr, epoch: epoch, due: cyc + int'($urandom_range(lat_min, lat_max))});
    cyc++;
  endtask

  // Reset lands between clock edges; outputs must drop before any edge arrives.
  task automatic apply_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_req_ready = 1'b0; redirect = 1'b0; hold = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_pc4", out_pc4, 32'd0);
    env_q.delete(); exp_q.delete(); out_log.delete(); inst_log.delete(); issued_log.delete();
    epoch++;
    exp_fetch = 32'h0; last_inst = 32'h0; last_pc4 = 32'h0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int viol;
    rst_n = 1'b0; redirect = 1'b0; redirect_addr = 32'h0; hold = 1'b0;
    imem_req_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    n_checks = 0; n_fail = 0; epoch = 0; cyc = 0; lat_min = 1; lat_max = 1; hold_pct = 0;
    stim_hold = 1'b0; stim_redirect = 1'b0; stim_ready = 1'b1; rand_ready = 1'b0; stim_raddr = 32'h0;
    exp_fetch = 32'h0; last_inst = 32'h0; last_pc4 = 32'h0;

    // Hold from reset: FIFO fills to DEPTH and fetch stalls.
    apply_reset();
    stim_hold = 1'b1;
    repeat (20) cycle();
    check("hold_valid", 32'(obs_valid), 32'd1);
    check("hold_head_pc4", obs_pc4, 32'h4);
    check("hold_req_off", 32'(obs_req), 32'd0);
    check("hold_issued_cnt", issued_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("hold_issue_addr", q_at(issued_log, i), 32'(4 * i));

    // Release: drain in order, fetch resumes at 0x10, then one instruction per cycle.
    stim_hold = 1'b0;
    out_log.delete(); inst_log.delete();
    repeat (16) cycle();
    check("drain_pop_cnt", out_log.size(), 32'd16);
    for (int i = 0; i < 4; i++) check("drain_pc4", q_at(out_log, i), 32'(4 * i + 4));
    check("drain_inst0", q_at(inst_log, 0), mem_word(32'h0));
    check("resume_addr", q_at(issued_log, 4), 32'h10);

    // Redirect with three requests in flight at latency 3.
    apply_reset();
    lat_min = 3; lat_max = 3;
    repeat (3) cycle();
    check("redir_inflight", issued_log.size(), 32'd3);
    stim_redirect = 1'b1; stim_raddr = 32'h100;
    cycle();
    stim_redirect = 1'b0;
    cycle();
    check("redir_req", 32'(obs_req), 32'd1);
    check("redir_addr", obs_addr, 32'h100);
    repeat (12) cycle();
    check("redir_first_pc4", q_at(out_log, 0), 32'h104);
    check("redir_first_inst", q_at(inst_log, 0), mem_word(32'h100));
    check("redir_second_pc4", q_at(out_log, 1), 32'h108);

    // Redirect in the same cycle as a response and a pop.
    apply_reset();
    lat_min = 1; lat_max = 1;
    repeat (10) cycle();
    stim_redirect = 1'b1; stim_raddr = 32'h200;
    cycle();
    check("same_cyc_valid", 32'(obs_valid), 32'd1);
    check("same_cyc_rvalid", 32'(obs_rvalid), 32'd1);
    stim_redirect = 1'b0;
    out_log.delete(); inst_log.delete();
    cycle();
    check("same_cyc_empty", 32'(obs_valid), 32'd0);
    check("same_cyc_req", 32'(obs_req), 32'd1);
    check("same_cyc_addr", obs_addr, 32'h200);
    repeat (6) cycle();
    check("same_cyc_first_pc4", q_at(out_log, 0), 32'h204);

    // Random ready, latency 1..5 and decode stalls.
    lat_min = 1; lat_max = 5; rand_ready = 1'b1; hold_pct = 30;
    out_log.delete(); inst_log.delete();
    repeat (300) cycle();
    rand_ready = 1'b0; hold_pct = 0; lat_max = 1;
    repeat (20) cycle();
    viol = 0;
    for (int i = 1; i < out_log.size(); i++)
      if (out_log[i] != out_log[i-1] + 32'd4) viol++;
    check("rand_pc4_step_viol", viol, 32'd0);
    check("rand_progress", 32'(out_log.size() > 20), 32'd1);

    // Asynchronous reset mid-burst, then restart from RESET_PC.
    check("pre_rst_valid", 32'(obs_valid), 32'd1);
    apply_reset();
    cycle();
    check("post_rst_req", 32'(obs_req), 32'd1);
    check("post_rst_addr", obs_addr, 32'h0);
    repeat (4) cycle();
    check("post_rst_pc4", q_at(out_log, 0), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
